// File: rtl/uart_transmitter_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding, line levels
// and default sizing.
`timescale 1ns/1ps
package uart_transmitter_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_FIFO_DEPTH = 4;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Encoding matches the receiver so both halves can be probed the same way.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_transmitter_tx_fifo.sv
// Byte buffer for the transmitter: extra-MSB pointers, registered full flag,
// read data taken straight from the storage registers at the read pointer.
`timescale 1ns/1ps
module uart_tx_fifo
  import uart_transmitter_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int FIFO_DEPTH = UART_FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 rd_en,
  output logic                 full,
  output logic                 empty,
  output logic [DATA_BITS-1:0] dout
);

  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int PTR_W  = ADDR_W + 1;

  logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic                 r_full;

  logic [PTR_W-1:0]     w_wr_ptr_nxt;
  logic [PTR_W-1:0]     w_rd_ptr_nxt;
  logic                 w_do_wr;
  logic                 w_do_rd;
  logic                 w_full_nxt;

  assign w_do_wr = wr_en & ~r_full;
  assign w_do_rd = rd_en & ~empty;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_wr_ptr_nxt = r_wr_ptr;
    w_rd_ptr_nxt = r_rd_ptr;
    if (w_do_wr) w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
    if (w_do_rd) w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);
  end

  assign w_full_nxt = (w_wr_ptr_nxt[PTR_W-1] != w_rd_ptr_nxt[PTR_W-1]) &&
                      (w_wr_ptr_nxt[ADDR_W-1:0] == w_rd_ptr_nxt[ADDR_W-1:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_full   <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_ptr_nxt;
      r_rd_ptr <= w_rd_ptr_nxt;
      r_full   <= w_full_nxt;
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wr_ptr[ADDR_W-1:0]] <= wr_data;
  end

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = r_full;
  assign dout  = r_mem[r_rd_ptr[ADDR_W-1:0]];

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: buffers bytes from a valid/ready port and shifts them out
// LSB-first, one line level per rising edge of the shared baud square wave.
`timescale 1ns/1ps
module uart_transmitter
  import uart_transmitter_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int FIFO_DEPTH = UART_FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_rate_signal,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 data_valid,
  output logic                 tx_ready,
  output logic                 uart_tx,
  output logic                 tx_busy,
  output logic                 overflow
);

  localparam int               CNT_W    = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

  tx_state_e            r_state;
  logic                 r_baud_q;
  logic                 r_uart_tx;
  logic                 r_overflow;
  logic [DATA_BITS-1:0] r_shift;
  logic [CNT_W-1:0]     r_bit_cnt;

  logic                 w_tick;
  logic                 w_wr_en;
  logic                 w_rd_en;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic [DATA_BITS-1:0] w_fifo_dout;

  assign w_tick   = baud_rate_signal & ~r_baud_q;
  assign tx_ready = ~w_fifo_full;
  assign w_wr_en  = data_valid & tx_ready;
  // A byte leaves the buffer only where a new frame begins: from IDLE or straight out of STOP.
  assign w_rd_en  = w_tick & ~w_fifo_empty & ((r_state == ST_IDLE) | (r_state == ST_STOP));

  uart_tx_fifo #(
    .DATA_BITS  (DATA_BITS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (w_wr_en),
    .wr_data (data),
    .rd_en   (w_rd_en),
    .full    (w_fifo_full),
    .empty   (w_fifo_empty),
    .dout    (w_fifo_dout)
  );

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_baud_q   <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_baud_q   <= baud_rate_signal;
      r_overflow <= data_valid & ~tx_ready;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_uart_tx <= STOP_BIT;
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (w_tick) begin
      unique case (r_state)
        ST_IDLE: begin
          if (!w_fifo_empty) begin
            r_shift   <= w_fifo_dout;
            r_uart_tx <= START_BIT;
            r_state   <= ST_START;
          end
        end
        ST_START: begin
          r_uart_tx <= r_shift[0];
          r_bit_cnt <= '0;
          r_state   <= ST_DATA;
        end
        ST_DATA: begin
          if (r_bit_cnt == LAST_BIT) begin
            r_uart_tx <= STOP_BIT;
            r_state   <= ST_STOP;
          end else begin
            r_shift   <= r_shift >> 1;
            r_uart_tx <= r_shift[1];
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
          end
        end
        ST_STOP: begin
          if (!w_fifo_empty) begin
            r_shift   <= w_fifo_dout;
            r_uart_tx <= START_BIT;
            r_state   <= ST_START;
          end else begin
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign uart_tx  = r_uart_tx;
  assign overflow = r_overflow;
  assign tx_busy  = (r_state != ST_IDLE) | ~w_fifo_empty;

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: a per-clock queue model of the link
// plus a line decoder that recovers bytes from the sampled serial stream.
`timescale 1ns/1ps
module tb_uart_transmitter;

  localparam int FIFO_DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_rate_signal;
  logic [7:0] data;
  logic       data_valid;
  logic       tx_ready;
  logic       uart_tx;
  logic       tx_busy;
  logic       overflow;

  uart_transmitter #(
    .DATA_BITS  (8),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .baud_rate_signal (baud_rate_signal),
    .data             (data),
    .data_valid       (data_valid),
    .tx_ready         (tx_ready),
    .uart_tx          (uart_tx),
    .tx_busy          (tx_busy),
    .overflow         (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: bytes waiting in the buffer, line levels still owed for the
  // current frame, and whether a frame (including its stop bit) is still on the line.
  logic [7:0] bytes_q[$];
  bit         bits_q[$];
  bit         in_frame  = 1'b0;
  bit         prev_baud = 1'b0;
  bit         exp_line  = 1'b1;
  bit         exp_ovf   = 1'b0;

  // Loopback record: line level seen after each tick, and bytes accepted since last clear.
  bit         line_log[$];
  logic [7:0] sent_q[$];

  bit         exp_seq [10] = '{0, 1, 1, 0, 1, 0, 0, 1, 0, 1};
  bit         baud_lvl = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic cycle(input bit valid, input logic [7:0] d, input bit baud, input bit do_rst = 1'b0);
    bit tick;
    bit accept;
    tick             = 1'b0;
    rst              = do_rst;
    data_valid       = valid;
    data             = d;
    baud_rate_signal = baud;
    baud_lvl         = baud;
    @(posedge clk);
    if (do_rst) begin
      bytes_q.delete();
      bits_q.delete();
      line_log.delete();
      sent_q.delete();
      in_frame  = 1'b0;
      prev_baud = 1'b0;
      exp_line  = 1'b1;
      exp_ovf   = 1'b0;
    end else begin
      tick      = baud && !prev_baud;
      prev_baud = baud;
      accept    = valid && (bytes_q.size() < FIFO_DEPTH);
      exp_ovf   = valid && !accept;
      if (tick) begin
        if (bits_q.size() == 0) begin
          if (bytes_q.size() > 0) begin
            logic [7:0] b;
            b = bytes_q.pop_front();
            bits_q.push_back(1'b0);
            for (int k = 0; k < 8; k++) bits_q.push_back(b[k]);
            bits_q.push_back(1'b1);
            in_frame = 1'b1;
          end else begin
            in_frame = 1'b0;
          end
        end
        exp_line = (bits_q.size() > 0) ? bits_q.pop_front() : 1'b1;
      end
      if (accept) begin
        bytes_q.push_back(d);
        sent_q.push_back(d);
      end
    end
    #1;
    check("uart_tx",  uart_tx,  exp_line);
    check("tx_ready", tx_ready, bytes_q.size() < FIFO_DEPTH);
    check("tx_busy",  tx_busy,  in_frame || (bytes_q.size() > 0));
    check("overflow", overflow, exp_ovf);
    if (tick) line_log.push_back(bit'(uart_tx));
  endtask

  task automatic idle_cycle(input bit baud);
    cycle(1'b0, 8'($urandom), baud);
  endtask

  task automatic write_byte(input logic [7:0] d);
    cycle(1'b1, d, baud_lvl);
  endtask

  task automatic bit_time(input int n = 1);
    for (int i = 0; i < n; i++) begin
      idle_cycle(1'b1);
      idle_cycle(1'b1);
      idle_cycle(1'b0);
      idle_cycle(1'b0);
    end
  endtask

  // Decode the sampled line as 8N1 and compare against the accepted bytes.
  task automatic check_loopback(input string tag);
    int         i;
    int         nrx;
    bit         complete;
    logic [7:0] b;
    i   = 0;
    nrx = 0;
    while (i < line_log.size()) begin
      if (line_log[i]) begin
        i++;
        continue;
      end
      complete = (i + 9) < line_log.size();
      check({tag, "_frame_complete"}, complete, 1'b1);
      if (!complete) break;
      for (int k = 0; k < 8; k++) b[k] = line_log[i + 1 + k];
      check({tag, "_stop_bit"}, line_log[i + 9], 1'b1);
      if (nrx < sent_q.size()) check({tag, "_byte"}, b, sent_q[nrx]);
      nrx++;
      i += 10;
    end
    check({tag, "_byte_count"}, nrx, sent_q.size());
    line_log.delete();
    sent_q.delete();
  endtask

  initial begin
    rst              = 1'b1;
    baud_rate_signal = 1'b0;
    data             = 8'h00;
    data_valid       = 1'b0;

    // Reset, then a single 8'h4B frame.
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1);
    check("reset_uart_tx", uart_tx, 1'b1);
    check("reset_tx_ready", tx_ready, 1'b1);
    check("reset_tx_busy", tx_busy, 1'b0);
    write_byte(8'h4B);
    bit_time(12);
    check("t1_tick_count", line_log.size(), 12);
    for (int i = 0; i < 10; i++) check("t1_seq", line_log[i], exp_seq[i]);
    check("t1_idle_after_a", line_log[10], 1'b1);
    check("t1_idle_after_b", line_log[11], 1'b1);
    check_loopback("t1_loop");

    // Three back-to-back frames; busy must still be high on the last stop bit.
    write_byte(8'h00);
    write_byte(8'hFF);
    write_byte(8'hA5);
    bit_time(30);
    check("t3_busy_on_last_stop", tx_busy, 1'b1);
    check("t3_line_ticks", line_log.size(), 30);
    bit_time(1);
    check("t3_busy_fell", tx_busy, 1'b0);
    check_loopback("t3_loop");

    // Baud stalled: fill the buffer, fifth write overflows.
    write_byte(8'h11);
    write_byte(8'h22);
    write_byte(8'h33);
    check("t4_ready_after3", tx_ready, 1'b1);
    write_byte(8'h44);
    check("t4_ready_after4", tx_ready, 1'b0);
    write_byte(8'h55);
    check("t4_overflow_pulse", overflow, 1'b1);
    idle_cycle(1'b0);
    check("t4_overflow_one_cycle", overflow, 1'b0);
    bit_time(45);
    check_loopback("t4_loop");

    // Reset during data bit 3 of 8'h5A.
    write_byte(8'h5A);
    bit_time(4);
    idle_cycle(1'b1);
    cycle(1'b0, 8'h00, 1'b1, 1'b1);
    check("t5_line_after_rst", uart_tx, 1'b1);
    check("t5_busy_after_rst", tx_busy, 1'b0);
    check("t5_ready_after_rst", tx_ready, 1'b1);
    idle_cycle(1'b0);
    bit_time(12);
    for (int i = 0; i < line_log.size(); i++) check("t5_line_quiet", line_log[i], 1'b1);
    check_loopback("t5_loop");

    // Write on the same clock as a tick while idle: frame begins one tick later.
    cycle(1'b1, 8'hC3, 1'b1);
    check("t6_no_start_on_write_tick", uart_tx, 1'b1);
    idle_cycle(1'b1);
    idle_cycle(1'b0);
    idle_cycle(1'b0);
    idle_cycle(1'b1);
    check("t6_start_next_tick", uart_tx, 1'b0);
    idle_cycle(1'b1);
    idle_cycle(1'b0);
    idle_cycle(1'b0);
    bit_time(11);
    check_loopback("t6_loop");

    // Randomized traffic: jittered baud period, occasional stalls, bursty writes.
    begin
      int half  = 2;
      int cnt   = 0;
      int stall = 0;
      bit lvl   = 1'b0;
      for (int c = 0; c < 3000; c++) begin
        if (stall > 0) begin
          stall--;
        end else begin
          cnt++;
          if (cnt >= half) begin
            cnt = 0;
            lvl = !lvl;
            if (lvl) half = $urandom_range(1, 4);
            if ($urandom_range(0, 99) == 0) stall = $urandom_range(5, 40);
          end
        end
        cycle($urandom_range(0, 99) < 20, 8'($urandom), lvl);
      end
    end
    bit_time(60);
    check_loopback("rand_loop");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
